// File: rtl/vga_pkg.sv
// Shared VGA timing constants, lock-state encoding, colours and datapath helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_pkg;

   // Nominal 640x480 timing, in pixel clocks (horizontal) and lines (vertical)
   localparam int H_TOTAL  = 800;
   localparam int H_PULSE  = 96;
   localparam int V_TOTAL  = 521;
   localparam int V_PULSE  = 2;
   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;

   localparam int LOCK_FRAMES_DEF = 2;

   localparam int CNT_W = 10;
   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [1:0] {
      LK_SEARCH = 2'd0,
      LK_VERIFY = 2'd1,
      LK_LOCKED = 2'd2
   } lock_state_t;

   // RRR_GGG_BB colour constants shared with the timing driver
   localparam logic [7:0] RGB_BLACK = 8'h00;
   localparam logic [7:0] RGB_WHITE = 8'hFF;
   localparam logic [7:0] RGB_RED   = 8'hE0;
   localparam logic [7:0] RGB_GREEN = 8'h1C;
   localparam logic [7:0] RGB_BLUE  = 8'h03;

   // Counters stick at all-ones instead of wrapping
   function automatic cnt_t sat_inc(input cnt_t v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   // One step of the per-frame rotate-xor pixel checksum
   function automatic logic [15:0] sum_step(input logic [15:0] s, input logic [7:0] c);
      return {s[14:0], s[15]} ^ {8'h00, c};
   endfunction

endpackage

// File: rtl/vga_sync_monitor_if.sv
// Bundles the VGA pin tap and the monitor's measurement/status results.
// Latency: n/a (wiring only).
// Backpressure: none; the tap is a passive observer of the VGA pins.
interface vga_sync_monitor_if;
   import vga_pkg::*;

   logic       pixEn;
   logic       hSync;
   logic       vSync;
   logic       bright;
   logic [7:0] rgb;

   cnt_t        hPos;
   cnt_t        vPos;
   logic        pixValid;
   logic [7:0]  pixRgb;
   cnt_t        lineLen;
   cnt_t        frameLines;
   logic [15:0] frameSum;
   logic        frameDone;
   logic        locked;
   logic        hErr;
   logic        vErr;

   modport master (
      output pixEn, hSync, vSync, bright, rgb,
      input  hPos, vPos, pixValid, pixRgb, lineLen, frameLines,
             frameSum, frameDone, locked, hErr, vErr
   );

   modport slave (
      input  pixEn, hSync, vSync, bright, rgb,
      output hPos, vPos, pixValid, pixRgb, lineLen, frameLines,
             frameSum, frameDone, locked, hErr, vErr
   );

endinterface

// File: rtl/vga_edge_meas.sv
// Sync falling-edge detector with period and low-width measurement against nominal values.
// Latency: fall/err_evt are combinational on the sample; period registers on the falling sample.
// Backpressure: none; edges sampled on smp, counters advance on cnt_stb.
module vga_edge_meas
   import vga_pkg::*;
#(
   parameter int TOTAL      = H_TOTAL,
   parameter int PULSE      = H_PULSE,
   // 1: the falling sample opens the new period (counts as 1)
   // 0: the falling sample's strobe still belongs to the period it closes
   parameter bit FALL_OPENS = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic smp,
   input  logic cnt_stb,
   input  logic sync_in,
   output logic fall,
   output cnt_t period,
   output logic err_evt
);

   logic prev;
   logic primed;
   logic seen;
   logic rise;
   cnt_t cnt;
   cnt_t wid;
   cnt_t cnt_end;

   // primed blocks a sync that is already low at reset release from reading as an edge
   assign fall    = smp & primed & prev & ~sync_in;
   assign rise    = smp & primed & ~prev & sync_in;
   assign cnt_end = FALL_OPENS ? cnt : (cnt_stb ? sat_inc(cnt) : cnt);
   assign err_evt = (fall & seen & (cnt_end != cnt_t'(TOTAL))) |
                    (rise & seen & (wid != cnt_t'(PULSE)));

   // Edge history, period counter and low-width counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev   <= 1'b1;
         primed <= 1'b0;
         seen   <= 1'b0;
         cnt    <= '0;
         wid    <= '0;
         period <= '0;
      end else if (smp) begin
         prev   <= sync_in;
         primed <= 1'b1;
         if (fall) begin
            seen   <= 1'b1;
            period <= cnt_end;
            cnt    <= FALL_OPENS ? cnt_t'(1) : cnt_t'(0);
            wid    <= cnt_stb ? cnt_t'(1) : cnt_t'(0);
         end else begin
            if (cnt_stb) cnt <= sat_inc(cnt);
            if (!sync_in && cnt_stb) wid <= sat_inc(wid);
         end
      end
   end

endmodule

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA tap: recovers pixel coordinates, checks sync timing, tracks lock, checksums frames.
// Latency: pixel outputs and status one pixEn sample after the input sample.
// Backpressure: none; state advances only on pixEn and holds otherwise.
module vga_sync_monitor
   import vga_pkg::*;
#(
   parameter int HTOTAL      = H_TOTAL,
   parameter int HPULSE      = H_PULSE,
   parameter int VTOTAL      = V_TOTAL,
   parameter int VPULSE      = V_PULSE,
   parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
   input  logic               clk,
   input  logic               clear,
   vga_sync_monitor_if.slave  mon
);

   localparam cnt_t LOCK_N = cnt_t'(LOCK_FRAMES);

   logic        h_fall;
   logic        v_fall;
   logic        h_err_evt;
   logic        v_err_evt;
   logic        new_err;
   logic        frame_err;
   logic        line_bright;
   cnt_t        x_cnt;
   cnt_t        y_cnt;
   cnt_t        x_cur;
   cnt_t        y_cur;
   cnt_t        good_cnt;
   logic [15:0] sum;
   logic [15:0] sum_base;
   lock_state_t state;

   vga_edge_meas #(.TOTAL(HTOTAL), .PULSE(HPULSE), .FALL_OPENS(1'b1)) u_h_meas (
      .clk(clk), .rst_n(clear), .smp(mon.pixEn), .cnt_stb(mon.pixEn),
      .sync_in(mon.hSync), .fall(h_fall), .period(mon.lineLen), .err_evt(h_err_evt)
   );

   // Vertical timing is counted in lines, so its counters step on hFall
   vga_edge_meas #(.TOTAL(VTOTAL), .PULSE(VPULSE), .FALL_OPENS(1'b0)) u_v_meas (
      .clk(clk), .rst_n(clear), .smp(mon.pixEn), .cnt_stb(h_fall),
      .sync_in(mon.vSync), .fall(v_fall), .period(mon.frameLines), .err_evt(v_err_evt)
   );

   assign new_err = h_err_evt | v_err_evt;

   // Coordinates and checksum as seen by this sample; a vFall sample starts the new frame
   always_comb begin
      x_cur    = h_fall ? cnt_t'(0) : x_cnt;
      y_cur    = y_cnt;
      if (h_fall && line_bright) y_cur = sat_inc(y_cnt);
      if (v_fall) y_cur = '0;
      sum_base = v_fall ? 16'h0000 : sum;
   end

   // Pixel datapath, frame checksum and sticky error flags
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         x_cnt         <= '0;
         y_cnt         <= '0;
         line_bright   <= 1'b0;
         sum           <= '0;
         mon.hPos      <= '0;
         mon.vPos      <= '0;
         mon.pixValid  <= 1'b0;
         mon.pixRgb    <= '0;
         mon.frameSum  <= '0;
         mon.frameDone <= 1'b0;
         mon.hErr      <= 1'b0;
         mon.vErr      <= 1'b0;
      end else begin
         mon.frameDone <= 1'b0;
         if (mon.pixEn) begin
            mon.pixValid <= mon.bright;
            mon.pixRgb   <= mon.rgb;
            x_cnt        <= x_cur;
            y_cnt        <= y_cur;
            line_bright  <= mon.bright | (line_bright & ~h_fall);
            if (mon.bright) begin
               mon.hPos <= x_cur;
               mon.vPos <= y_cur;
               x_cnt    <= sat_inc(x_cur);
               sum      <= sum_step(sum_base, mon.rgb);
            end else begin
               sum      <= sum_base;
            end
            if (v_fall) begin
               mon.frameSum  <= sum;
               mon.frameDone <= 1'b1;
            end
            if (h_err_evt) mon.hErr <= 1'b1;
            if (v_err_evt) mon.vErr <= 1'b1;
         end
      end
   end

   // Lock FSM: needs LOCK_FRAMES clean frames after the first vFall; any new error drops lock
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state      <= LK_SEARCH;
         good_cnt   <= '0;
         frame_err  <= 1'b0;
         mon.locked <= 1'b0;
      end else if (mon.pixEn) begin
         frame_err <= v_fall ? 1'b0 : (frame_err | new_err);
         case (state)
            LK_SEARCH: begin
               if (v_fall) begin
                  state    <= LK_VERIFY;
                  good_cnt <= '0;
               end
            end
            LK_VERIFY: begin
               if (v_fall) begin
                  if (frame_err | new_err) begin
                     state    <= LK_SEARCH;
                     good_cnt <= '0;
                  end else if (sat_inc(good_cnt) == LOCK_N) begin
                     state      <= LK_LOCKED;
                     good_cnt   <= '0;
                     mon.locked <= 1'b1;
                  end else begin
                     good_cnt <= sat_inc(good_cnt);
                  end
               end
            end
            LK_LOCKED: begin
               if (new_err) begin
                  state      <= LK_SEARCH;
                  mon.locked <= 1'b0;
               end
            end
            default: begin
               state      <= LK_SEARCH;
               mon.locked <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a scaled-down raster (24x14 with a 15x7 active window).
// Latency: checks pixel outputs one pixEn sample after each input sample.
// Backpressure: n/a; pixEn strobes every other clock.
module tb_vga_sync_monitor;

   localparam int HT   = 24;
   localparam int HP   = 4;
   localparam int VT   = 14;
   localparam int VP   = 2;
   localparam int HB0  = 6;
   localparam int HACT = 15;
   localparam int VB0  = 3;
   localparam int VACT = 7;

   logic clk = 1'b0;
   logic clear;

   vga_sync_monitor_if bus();

   vga_sync_monitor #(
      .HTOTAL(HT), .HPULSE(HP), .VTOTAL(VT), .VPULSE(VP), .LOCK_FRAMES(2)
   ) dut (
      .clk(clk),
      .clear(clear),
      .mon(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int frame_idx = -1;
   int cur_v = 0;
   int cur_h = 0;
   int fd_cnt = 0;
   logic [15:0] cap_sum[$];
   logic [9:0]  cap_lines[$];
   logic [15:0] model_sum[0:31];
   logic locked_q = 1'b0;
   logic herr_q = 1'b0;
   int lock_rise_frame = -1;
   int lock_rise_v = -1;
   int lock_rise_h = -1;
   int herr_v = -1;
   time lock_fall_t = 0;
   time herr_t = 0;
   logic [9:0] len_at_herr = '0;
   int pix_bad = 0;
   int hpos_max = 0;
   int vpos_max = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic observe();
      if (bus.frameDone === 1'b1) begin
         fd_cnt++;
         cap_sum.push_back(bus.frameSum);
         cap_lines.push_back(bus.frameLines);
      end
      if (bus.locked === 1'b1 && !locked_q) begin
         lock_rise_frame = frame_idx;
         lock_rise_v     = cur_v;
         lock_rise_h     = cur_h;
      end
      if (bus.locked !== 1'b1 && locked_q) lock_fall_t = $time;
      if (bus.hErr === 1'b1 && !herr_q) begin
         herr_t      = $time;
         herr_v      = cur_v;
         len_at_herr = bus.lineLen;
      end
      locked_q = (bus.locked === 1'b1);
      herr_q   = (bus.hErr === 1'b1);
   endtask

   // one pixEn sample followed by one idle clock
   task automatic sample(input logic hs, input logic vs, input logic br,
                         input logic [7:0] c, input int eh, input int ev);
      bus.hSync  = hs;
      bus.vSync  = vs;
      bus.bright = br;
      bus.rgb    = c;
      bus.pixEn  = 1'b1;
      @(posedge clk); #1;
      if (bus.pixValid !== br) pix_bad++;
      if (br) begin
         if (bus.hPos !== 10'(eh) || bus.vPos !== 10'(ev) || bus.pixRgb !== c) pix_bad++;
         if (int'(bus.hPos) > hpos_max) hpos_max = int'(bus.hPos);
         if (int'(bus.vPos) > vpos_max) vpos_max = int'(bus.vPos);
      end
      observe();
      bus.pixEn = 1'b0;
      @(posedge clk); #1;
      observe();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) sample(1'b1, 1'b1, 1'b0, 8'h00, 0, 0);
   endtask

   // short_v: line one clock short; narrow_v: line with hSync one clock narrow;
   // vlow: lines vSync is held low; ff: constant white active area
   task automatic frame(input int short_v, input int narrow_v, input int vlow, input bit ff);
      logic [15:0] ms;
      logic        br;
      logic [7:0]  c;
      int          len;
      int          pw;
      ms = 16'h0000;
      frame_idx++;
      for (int v = 0; v < VT; v++) begin
         len = (v == short_v) ? HT - 1 : HT;
         pw  = (v == narrow_v) ? HP - 1 : HP;
         for (int h = 0; h < len; h++) begin
            cur_v = v;
            cur_h = h;
            br = (v >= VB0) && (v < VB0 + VACT) && (h >= HB0) && (h < HB0 + HACT);
            c  = ff ? 8'hFF : 8'(h * 7 + v * 13 + frame_idx);
            if (br) ms = {ms[14:0], ms[15]} ^ {8'h00, c};
            sample(h >= pw, v >= vlow, br, c, h - HB0, v - VB0);
         end
      end
      model_sum[frame_idx] = ms;
   endtask

   task automatic do_reset();
      clear = 1'b0;
      #7;
      clear = 1'b1;
   endtask

   initial begin
      bus.pixEn  = 1'b0;
      bus.hSync  = 1'b1;
      bus.vSync  = 1'b1;
      bus.bright = 1'b0;
      bus.rgb    = 8'h00;
      clear      = 1'b0;
      #12;

      // reset state
      chk("rst_pix", {bus.hPos, bus.vPos, bus.pixValid, bus.pixRgb}, 0);
      chk("rst_lineLen", bus.lineLen, 0);
      chk("rst_frameLines", bus.frameLines, 0);
      chk("rst_frameSum", bus.frameSum, 0);
      chk("rst_flags", {bus.frameDone, bus.locked, bus.hErr, bus.vErr}, 0);
      clear = 1'b1;
      idle(4);

      // nominal frames, lock on the third vFall
      frame(-1, -1, VP, 1'b0);
      frame(-1, -1, VP, 1'b0);
      chk("lock_before_3rd_vfall", bus.locked, 0);
      frame(-1, -1, VP, 1'b0);
      chk("lock_rise_frame", lock_rise_frame, 2);
      chk("lock_rise_pos", {16'(lock_rise_v), 16'(lock_rise_h)}, 0);
      frame(-1, -1, VP, 1'b1);
      frame(-1, -1, VP, 1'b0);
      chk("nom_lineLen", bus.lineLen, HT);
      chk("nom_frameLines", (cap_lines.size() > 4) ? 32'(cap_lines[4]) : 32'hFFFF_FFFF, VT);
      chk("nom_errs", {bus.hErr, bus.vErr}, 0);
      chk("nom_locked", bus.locked, 1);
      chk("frameDone_count", fd_cnt, 5);
      chk("sum_pattern", (cap_sum.size() > 2) ? 32'(cap_sum[2]) : 32'hFFFF_FFFF, 32'(model_sum[1]));
      chk("sum_white", (cap_sum.size() > 4) ? 32'(cap_sum[4]) : 32'hFFFF_FFFF, 32'h0000_AA55);
      chk("hpos_span", hpos_max, HACT - 1);
      chk("vpos_span", vpos_max, VACT - 1);
      chk("pix_stream", pix_bad, 0);

      // short line after lock, then relock with hErr still set
      frame(5, -1, VP, 1'b0);
      chk("short_herr", bus.hErr, 1);
      chk("short_herr_line", herr_v, 6);
      chk("short_lineLen", len_at_herr, HT - 1);
      chk("short_lock_drop", (lock_fall_t == herr_t && herr_t != 0) ? 1 : 0, 1);
      chk("short_unlocked", bus.locked, 0);
      frame(-1, -1, VP, 1'b0);
      frame(-1, -1, VP, 1'b0);
      chk("relock_not_yet", bus.locked, 0);
      frame(-1, -1, VP, 1'b0);
      chk("relock_frame", lock_rise_frame, 8);
      chk("relock_herr_sticky", bus.hErr, 1);
      chk("relock_lineLen", bus.lineLen, HT);

      // clear mid-line, released with hSync held low
      for (int h = 0; h < 10; h++) sample(h >= HP, 1'b1, 1'b0, 8'h00, 0, 0);
      #3;
      clear = 1'b0;
      #1;
      chk("clear_pix", {bus.hPos, bus.vPos, bus.pixValid, bus.pixRgb}, 0);
      chk("clear_meas", {bus.lineLen, bus.frameSum, bus.locked, bus.hErr}, 0);
      chk("clear_misc", {bus.frameLines, bus.frameDone, bus.vErr}, 0);
      bus.hSync = 1'b0;
      #3;
      clear = 1'b1;
      for (int i = 0; i < 10; i++) sample(1'b0, 1'b1, 1'b0, 8'h00, 0, 0);
      for (int i = 0; i < 5; i++) sample(1'b1, 1'b1, 1'b0, 8'h00, 0, 0);
      sample(1'b0, 1'b1, 1'b0, 8'h00, 0, 0);
      chk("release_no_false_edge", bus.hErr, 0);
      chk("release_lineLen", bus.lineLen, 15);

      // hSync one clock narrow
      do_reset();
      idle(4);
      frame(-1, 4, VP, 1'b0);
      frame(-1, -1, VP, 1'b0);
      chk("narrow_herr", bus.hErr, 1);
      chk("narrow_herr_line", herr_v, 4);
      chk("narrow_lineLen", len_at_herr, HT);
      chk("narrow_lineLen_end", bus.lineLen, HT);
      chk("narrow_verr", bus.vErr, 0);

      // vSync held low for three lines
      do_reset();
      idle(4);
      frame(-1, -1, 3, 1'b0);
      frame(-1, -1, VP, 1'b0);
      chk("vwide_verr", bus.vErr, 1);
      chk("vwide_frameLines", bus.frameLines, VT);
      chk("vwide_herr", bus.hErr, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
